// File: rtl/reg_file_pkg.sv
// Shared types, write-mode encodings and the write-merge helper for reg_file_mp.
package reg_file_pkg;

    // Widest data path the merge helper supports; narrower widths are zero-extended.
    localparam int unsigned MAX_DW = 64;

    typedef logic [1:0] wr_mode_t;

    localparam wr_mode_t WR_FULL = 2'b00;
    localparam wr_mode_t WR_LO   = 2'b01;
    localparam wr_mode_t WR_HI   = 2'b10;
    localparam wr_mode_t WR_LINK = 2'b11;

    // Builds the value written for a given mode; half is DW/2 of the caller.
    // Both half modes take the new bits from the low half of data.
    function automatic logic [MAX_DW-1:0] merge(
        input logic [MAX_DW-1:0] old_val,
        input logic [MAX_DW-1:0] data,
        input logic [MAX_DW-1:0] pc_val,
        input wr_mode_t          mode,
        input int unsigned       half
    );
        logic [MAX_DW-1:0] lo_mask;
        logic [MAX_DW-1:0] result;
        lo_mask = (MAX_DW'(1) << half) - MAX_DW'(1);
        case (mode)
            WR_LO:   result = (old_val & ~lo_mask) | (data & lo_mask);
            WR_HI:   result = (old_val & lo_mask) | ((data & lo_mask) << half);
            WR_LINK: result = pc_val;
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy scoreboard: set/clear with set priority and the read hazard check.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NR          = 16,
    parameter int unsigned AW          = $clog2(NR),
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic [AW-1:0] i_src_a,
    input  logic [AW-1:0] i_src_b,
    output logic [NR-1:0] o_busy,
    output logic          o_hazard_c
);

    logic [NR-1:0] r_busy;
    logic [NR-1:0] w_busy_nxt;
    logic          w_set_ok;
    logic          w_haz_a;
    logic          w_haz_b;

    assign w_set_ok = i_set_en && !((ZERO_REG_EN != 0) && (i_set_addr == '0));

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (w_set_ok) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A source being written this cycle is satisfied by the bypass.
    assign w_haz_a    = r_busy[i_src_a] && !(i_clr_en && (i_clr_addr == i_src_a));
    assign w_haz_b    = r_busy[i_src_b] && !(i_clr_en && (i_clr_addr == i_src_b));
    assign o_hazard_c = w_haz_a || w_haz_b;
    assign o_busy     = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised 2-read/1-write register file with merge-mode writes, bypass and busy scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned NR          = 16,
    parameter int unsigned AW          = $clog2(NR),
    parameter int unsigned LINK_REG    = NR - 1,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic          rd_valid,
    output logic          rd_hazard,
    input  logic          wr_en,
    input  logic [1:0]    wr_mode,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] pc,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_addr,
    output logic [NR-1:0] busy
);

    localparam int unsigned HALF = DW / 2;

    logic [DW-1:0] r_regs [NR];
    logic [DW-1:0] r_rd_data_a;
    logic [DW-1:0] r_rd_data_b;
    logic          r_rd_valid;
    logic          r_rd_hazard;

    logic [AW-1:0] w_tgt;
    logic [DW-1:0] w_merged;
    logic          w_wr_fire;
    logic          w_byp_a;
    logic          w_byp_b;
    logic [DW-1:0] w_arr_a;
    logic [DW-1:0] w_arr_b;
    logic          w_hazard;

    assign w_tgt    = (wr_mode == WR_LINK) ? AW'(LINK_REG) : wr_addr;
    assign w_merged = DW'(merge(MAX_DW'(r_regs[w_tgt]), MAX_DW'(wr_data), MAX_DW'(pc),
                                wr_mode_t'(wr_mode), HALF));

    // Writes to a hard-wired zero register are dropped and never bypass.
    assign w_wr_fire = wr_en && !((ZERO_REG_EN != 0) && (w_tgt == '0));
    assign w_byp_a   = w_wr_fire && (w_tgt == rd_addr_a);
    assign w_byp_b   = w_wr_fire && (w_tgt == rd_addr_b);

    assign w_arr_a = ((ZERO_REG_EN != 0) && (rd_addr_a == '0)) ? '0 : r_regs[rd_addr_a];
    assign w_arr_b = ((ZERO_REG_EN != 0) && (rd_addr_b == '0)) ? '0 : r_regs[rd_addr_b];

    reg_scoreboard #(
        .NR          (NR),
        .AW          (AW),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_clr_en   (wr_en),
        .i_clr_addr (w_tgt),
        .i_set_en   (sb_set),
        .i_set_addr (sb_addr),
        .i_src_a    (rd_addr_a),
        .i_src_b    (rd_addr_b),
        .o_busy     (busy),
        .o_hazard_c (w_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_hazard <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_regs[w_tgt] <= w_merged;
            end
            if (rd_en) begin
                r_rd_data_a <= w_byp_a ? w_merged : w_arr_a;
                r_rd_data_b <= w_byp_b ? w_merged : w_arr_b;
            end
            r_rd_valid  <= rd_en;
            r_rd_hazard <= rd_en && w_hazard;
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;
    assign rd_hazard = r_rd_hazard;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance plain, one with the zero register enabled.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pc;
    logic        sb_set;
    logic [3:0]  sb_addr;

    logic [31:0] rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
    logic        rd_valid, rd_hazard, z_rd_valid, z_rd_hazard;
    logic [15:0] busy, z_busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_mp #(.DW(32), .NR(16), .ZERO_REG_EN(0)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid), .rd_hazard(rd_hazard),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data), .pc(pc),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy)
    );

    reg_file_mp #(.DW(32), .NR(16), .ZERO_REG_EN(1)) dut_z (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b), .rd_valid(z_rd_valid),
        .rd_hazard(z_rd_hazard), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc(pc), .sb_set(sb_set), .sb_addr(sb_addr), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_mode = WR_FULL; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic wr(input logic [1:0] m, input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_mode = m; wr_addr = a; wr_data = d;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
    endtask

    task automatic sb(input logic [3:0] a);
        sb_set = 1'b1; sb_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        pc  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_a", rd_data_a, 32'h0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_busy", busy, 16'h0);
        #2 rst = 1'b0;

        // Full write then dual read of the same register
        wr(WR_FULL, 4'd4, 32'h1234_5678); tick();
        idle(); rd(4'd4, 4'd4); tick();
        check("full_a", rd_data_a, 32'h1234_5678);
        check("full_b", rd_data_b, 32'h1234_5678);
        check("full_valid", rd_valid, 1'b1);

        // Half writes, observed through bypass and then the array
        idle(); wr(WR_FULL, 4'd4, 32'hAAAA_AAAA); tick();
        idle(); wr(WR_LO, 4'd4, 32'h0000_BEEF); rd(4'd4, 4'd4); tick();
        check("lo_byp", rd_data_a, 32'hAAAA_BEEF);
        idle(); wr(WR_HI, 4'd4, 32'h0000_CAFE); rd(4'd4, 4'd0); tick();
        check("hi_byp", rd_data_a, 32'hCAFE_BEEF);
        idle(); rd(4'd4, 4'd4); tick();
        check("hi_arr", rd_data_b, 32'hCAFE_BEEF);

        // Link mode targets r15 regardless of wr_addr
        idle(); wr(WR_FULL, 4'd3, 32'h0000_0033); tick();
        idle(); wr(WR_LINK, 4'd3, 32'hDEAD_0000); pc = 32'h0000_0100; rd(4'd15, 4'd3); tick();
        check("link_byp", rd_data_a, 32'h0000_0100);
        check("link_r3_byp", rd_data_b, 32'h0000_0033);
        idle(); rd(4'd15, 4'd3); tick();
        check("link_r15", rd_data_a, 32'h0000_0100);
        check("link_r3", rd_data_b, 32'h0000_0033);

        idle(); tick();
        check("hold_valid", rd_valid, 1'b0);
        check("hold_data", rd_data_a, 32'h0000_0100);

        // Scoreboard and hazard
        idle(); sb(4'd7); tick();
        check("sb_busy7", busy, 16'h0080);
        idle(); rd(4'd7, 4'd2); tick();
        check("haz_a", rd_hazard, 1'b1);
        idle(); wr(WR_FULL, 4'd7, 32'h0000_0077); rd(4'd7, 4'd7); tick();
        check("haz_clr", rd_hazard, 1'b0);
        check("haz_clr_data", rd_data_a, 32'h0000_0077);
        check("haz_clr_busy", busy, 16'h0000);
        idle(); wr(WR_FULL, 4'd5, 32'h0000_0055); sb(4'd5); tick();
        check("set_wins", busy, 16'h0020);
        idle(); rd(4'd2, 4'd5); tick();
        check("haz_b", rd_hazard, 1'b1);

        // Register 0: hard-wired zero vs ordinary
        idle(); wr(WR_FULL, 4'd0, 32'hFFFF_FFFF); sb(4'd0); rd(4'd0, 4'd0); tick();
        check("z0_nobyp", z_rd_data_a, 32'h0);
        check("z0_haz", z_rd_hazard, 1'b0);
        check("r0_byp", rd_data_a, 32'hFFFF_FFFF);
        idle(); rd(4'd0, 4'd0); tick();
        check("z0_read", z_rd_data_a, 32'h0);
        check("z0_busy", z_busy, 16'h0020);
        check("z0_haz2", z_rd_hazard, 1'b0);
        check("r0_read", rd_data_b, 32'hFFFF_FFFF);
        check("r0_busy", busy, 16'h0021);
        check("r0_haz", rd_hazard, 1'b1);

        // Set up busy=0x0080 with r4 nonzero, then reset between edges
        idle(); wr(WR_FULL, 4'd5, 32'h0); tick();
        idle(); wr(WR_FULL, 4'd0, 32'h0); sb(4'd7); tick();
        check("pre_busy", busy, 16'h0080);
        idle(); rd(4'd4, 4'd4); tick();
        check("pre_r4", rd_data_a, 32'hCAFE_BEEF);
        #3;
        wr(WR_FULL, 4'd4, 32'h0000_0001); sb(4'd7); rd(4'd4, 4'd4);
        rst = 1'b1;
        #1;
        check("arst_a", rd_data_a, 32'h0);
        check("arst_b", rd_data_b, 32'h0);
        check("arst_valid", rd_valid, 1'b0);
        check("arst_haz", rd_hazard, 1'b0);
        check("arst_busy", busy, 16'h0);
        check("arst_zbusy", z_busy, 16'h0);
        @(posedge clk);
        #3;
        idle();
        rst = 1'b0;
        rd(4'd4, 4'd4); tick();
        check("post_r4", rd_data_a, 32'h0);
        check("post_valid", rd_valid, 1'b1);
        check("post_busy", busy, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised register file for the processor datapath, replacing the fixed 16×32 bank. It provides two synchronous read ports, one write port with full, low-half, high-half and link write modes, and same-cycle write-to-read bypass. A per-register busy scoreboard flags read-after-write hazards to the issue logic. The block sits between decode (read addresses, scoreboard set) and writeback (write port, PC link).

## Interface
Parameters:
- DW, 32, data width in bits; must be even.
- NR, 16, number of registers; power of two, at least 4.
- AW, $clog2(NR), register address width.
- LINK_REG, NR-1, register written by link mode.
- ZERO_REG_EN, 0, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  1  sample read addresses this cycle
- rd_addr_a  in  AW  read port A address
- rd_addr_b  in  AW  read port B address
- rd_data_a  out  DW  registered read data A
- rd_data_b  out  DW  registered read data B
- rd_valid  out  1  rd_data_* updated by the previous cycle's rd_en
- rd_hazard  out  1  registered; a sampled source was busy
- wr_en  in  1  write request
- wr_mode  in  2  write mode: 00 full, 01 low half, 10 high half, 11 link
- wr_addr  in  AW  write address; ignored in link mode
- wr_data  in  DW  write data
- pc  in  DW  value written in link mode
- sb_set  in  1  mark sb_addr pending (producer issued)
- sb_addr  in  AW  scoreboard set address
- busy  out  NR  current scoreboard vector

## Operation
- Write target address `T` is wr_addr, or LINK_REG when wr_mode is 11.
- Merged value `M` depends on the mode:
  - full: wr_data.
  - low half: {reg[T][DW-1:DW/2], wr_data[DW/2-1:0]}.
  - high half: {wr_data[DW/2-1:0], reg[T][DW/2-1:0]}.
  - link: pc.
- The high-half mode takes the low half of wr_data.
- Read with rd_en=1: rd_data_x gets reg[addr_x]. If wr_en=1 and T==addr_x in the same cycle, rd_data_x gets M (bypass).
- rd_en=0: rd_data_* hold their value; rd_valid goes to 0.
- Scoreboard:
  - wr_en clears busy[T].
  - sb_set sets busy[sb_addr].
  - If both hit the same register in one cycle, set wins.
- rd_hazard, captured when rd_en=1, is high if either source is busy and that source is not being cleared by a write in the same cycle.
- With ZERO_REG_EN=1:
  - writes with T==0 are dropped and do not bypass.
  - reads of register 0 return 0.
  - sb_set to register 0 is ignored.
- A write and a read of the same register in the same cycle are legal and follow the bypass rule. Both read ports may use the same address.

## Timing
- Reset, asynchronous: all registers, rd_data_a/b, rd_valid, rd_hazard and busy go to 0 immediately. An in-flight read or write is discarded. The first rising edge after rst deasserts behaves normally.
- Write latency: registered at the edge where wr_en=1; visible through the array on the next cycle, and through bypass in the same cycle.
- Read latency: 1 cycle. rd_en at edge n gives rd_data/rd_valid/rd_hazard valid after edge n.
- busy reflects set/clear after the edge on which they occur.
- No handshake backpressure: the block never stalls. The issue logic holds the instruction while rd_hazard=1.

## Structure
- reg_file_pkg:
  - WR_FULL, WR_LO, WR_HI, WR_LINK mode constants.
  - wr_mode_t typedef (2 bits).
  - merge function producing M from old value, data, pc and mode.
- Sub-module reg_scoreboard (NR, AW): holds busy, set/clear priority and the ZERO_REG_EN mask, and computes the hazard.
- Top level: register array, bypass muxes, output registers.

## Test plan
- Reset, then write 0x12345678 full to r4; read r4 on A and B next cycle. Expect rd_data_a = rd_data_b = 0x12345678 and rd_valid=1.
- r4=0xAAAAAAAA. Write low half 0x0000BEEF, then high half 0x0000CAFE. Expect r4 = 0xAAAABEEF, then 0xCAFEBEEF.
- Link mode with pc=0x00000100 and wr_addr=3. Expect r15=0x100 and r3 unchanged. Same cycle, read r15 with rd_en: expect 0x100 via bypass.
- sb_set r7, then read r7 and r2. Expect rd_hazard=1 and busy[7]=1. Write r7 while reading r7 in the same cycle: expect rd_hazard=0, the bypassed data, and busy[7]=0. Simultaneous set and write on r5: busy[5] stays 1.
- ZERO_REG_EN=1: write 0xFFFFFFFF to r0 and sb_set r0. Expect a read of r0 = 0, busy[0]=0 and rd_hazard=0.
- Assert rst mid-stream, between edges, with busy=0x0080 and r4 nonzero. Expect all outputs and busy at 0 without a clock edge, and a read of r4 after release = 0.
